bus_cycle_controller: RTL and testbench

BUS_CYCLE_CONTROLLER -- requirements
Module: bus_cycle_controller

---
 rtl/bus_cycle_controller_pkg.sv | 16 +
 rtl/bus_cycle_controller_sync_2ff.sv | 21 ++
 rtl/bus_cycle_controller.sv | 172 +++++++++++++++++
 tb/tb_bus_cycle_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_cycle_controller_pkg.sv
// Shared types and constants for the 6809 bus cycle controller.
// Holds the FSM state encoding, channel-count ceiling and the timeout read value.
package bus_cycle_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  localparam int         NUM_CH_MAX    = 8;
  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

endpackage

// File: rtl/bus_cycle_controller_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; 2 clk latency, no backpressure.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bus_cycle_controller.sv
// 6809 bus cycle controller: decodes the address to one of NUM_CH channels and runs the access.
// Latency ~3 clk from Q rise to strobe; backpressure via o_MRDY stretch (BUS_CYCLE_CONTROLLER_TIMEOUT_EN bounds it).
module bus_cycle_controller
  import bus_cycle_controller_pkg::*;
#(
  parameter int                   NUM_CH   = 4,
  // Channel 0 in the LSBs: ch0=A000, ch1=A001, ch2=Fxxx, ch3=0xxx.
  parameter logic [16*NUM_CH-1:0] CH_BASE  = {16'h0000, 16'hF000, 16'hA001, 16'hA000},
  parameter logic [16*NUM_CH-1:0] CH_MASK  = {16'hF000, 16'hF000, 16'hFFFF, 16'hFFFF},
  parameter int                   WAIT_MAX = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           i_ADDRESS_BUS,
  input  logic                  i_RW,
  input  logic                  i_E,
  input  logic                  i_Q,
  input  logic [7:0]            i_DATA,
  input  logic [8*NUM_CH-1:0]   i_ch_rdata,
  input  logic [NUM_CH-1:0]     i_ch_ready,
  output logic [7:0]            o_DATA,
  output logic                  o_DATA_OE,
  output logic [NUM_CH-1:0]     o_ch_ce,
  output logic                  o_ch_rd_stb,
  output logic                  o_ch_wr_stb,
  output logic [7:0]            o_wdata,
  output logic                  o_MRDY,
  output logic                  o_DBEN,
  output logic                  o_timeout_err
);

  state_t              state;
  logic                e_s, q_s, e_d, q_d;
  logic                q_rise, e_fall;
  logic                rw_lat;
  logic [NUM_CH-1:0]   hit_oh, sel_oh, src_oh;
  logic [7:0]          rdata_mux;
  logic                ready_sel;
  logic                timeout_hit;

  sync_2ff u_sync_e (.clk(clk), .reset(reset), .d(i_E), .q(e_s));
  sync_2ff u_sync_q (.clk(clk), .reset(reset), .d(i_Q), .q(q_s));

  assign q_rise = q_s & ~q_d;
  assign e_fall = ~e_s & e_d;

  // Descending scan so the lowest matching channel overwrites the rest.
  always_comb begin
    hit_oh = '0;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      if (((i_ADDRESS_BUS ^ CH_BASE[16*n +: 16]) & CH_MASK[16*n +: 16]) == 16'h0000)
        hit_oh = NUM_CH'(1) << n;
    end
  end

  assign src_oh    = (state == DECODE) ? hit_oh : sel_oh;
  assign ready_sel = |(i_ch_ready & src_oh);

  always_comb begin
    rdata_mux = 8'h00;
    for (int n = 0; n < NUM_CH; n++) begin
      if (src_oh[n])
        rdata_mux = i_ch_rdata[8*n +: 8];
    end
  end

  // Gated directly on synchronised E so the drive window tracks E without a clock of lag.
  assign o_DATA_OE = ((state == ACCESS) || (state == DONE)) && e_s && rw_lat && (|sel_oh);

`ifdef BUS_CYCLE_CONTROLLER_TIMEOUT_EN
  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (wait_cnt == CNT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt      <= '0;
      o_timeout_err <= 1'b0;
    end else if (state == DECODE) begin
      wait_cnt <= '0;
    end else if ((state == WAIT) && !ready_sel) begin
      wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit)
        o_timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      e_d         <= 1'b0;
      q_d         <= 1'b0;
      sel_oh      <= '0;
      rw_lat      <= 1'b0;
      o_DATA      <= 8'h00;
      o_ch_ce     <= '0;
      o_ch_rd_stb <= 1'b0;
      o_ch_wr_stb <= 1'b0;
      o_wdata     <= 8'h00;
      o_MRDY      <= 1'b1;
      o_DBEN      <= 1'b1;
    end else begin
      e_d         <= e_s;
      q_d         <= q_s;
      o_ch_rd_stb <= 1'b0;
      o_ch_wr_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (q_rise) begin
            state  <= DECODE;
            o_DBEN <= ~(|hit_oh);
          end
        end
        DECODE: begin
          sel_oh <= hit_oh;
          rw_lat <= i_RW;
          if (!i_RW)
            o_wdata <= i_DATA;
          if (!(|hit_oh)) begin
            state  <= DONE;
            o_DBEN <= 1'b1;
          end else begin
            o_ch_ce     <= hit_oh;
            o_DBEN      <= 1'b0;
            o_ch_rd_stb <= i_RW;
            o_ch_wr_stb <= ~i_RW;
            if (ready_sel) begin
              state <= ACCESS;
              if (i_RW)
                o_DATA <= rdata_mux;
            end else begin
              state  <= WAIT;
              o_MRDY <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (ready_sel) begin
            state  <= ACCESS;
            o_MRDY <= 1'b1;
            if (rw_lat)
              o_DATA <= rdata_mux;
          end else if (timeout_hit) begin
            state  <= ACCESS;
            o_MRDY <= 1'b1;
            if (rw_lat)
              o_DATA <= TIMEOUT_RDATA;
          end
        end
        ACCESS: begin
          if (e_fall) begin
            state   <= DONE;
            o_ch_ce <= '0;
            o_DBEN  <= 1'b1;
          end
        end
        DONE: begin
          o_ch_ce <= '0;
          o_DBEN  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed bench: stimulus pushes expected per-cycle results, a monitor accumulates DUT outputs and compares.
module tb_bus_cycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] i_ADDRESS_BUS;
  logic        i_RW, i_E, i_Q;
  logic [7:0]  i_DATA;
  logic [31:0] i_ch_rdata;
  logic [3:0]  i_ch_ready;
  logic [7:0]  o_DATA;
  logic        o_DATA_OE;
  logic [3:0]  o_ch_ce;
  logic        o_ch_rd_stb, o_ch_wr_stb;
  logic [7:0]  o_wdata;
  logic        o_MRDY, o_DBEN, o_timeout_err;

  always #5 clk = ~clk;

  bus_cycle_controller #(.NUM_CH(4), .WAIT_MAX(64)) dut (
    .clk(clk), .reset(reset),
    .i_ADDRESS_BUS(i_ADDRESS_BUS), .i_RW(i_RW), .i_E(i_E), .i_Q(i_Q), .i_DATA(i_DATA),
    .i_ch_rdata(i_ch_rdata), .i_ch_ready(i_ch_ready),
    .o_DATA(o_DATA), .o_DATA_OE(o_DATA_OE), .o_ch_ce(o_ch_ce),
    .o_ch_rd_stb(o_ch_rd_stb), .o_ch_wr_stb(o_ch_wr_stb), .o_wdata(o_wdata),
    .o_MRDY(o_MRDY), .o_DBEN(o_DBEN), .o_timeout_err(o_timeout_err)
  );

  typedef struct {
    logic [3:0] ce;
    int         rd;
    int         wr;
    logic       dben_low;
    logic       oe;
    logic [7:0] data;
    int         mrdy;
    logic [7:0] wdata;
    logic       toerr;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  logic end_req = 1'b0;
  logic clr_req = 1'b0;

  int         rd_cnt, wr_cnt, mrdy_low, oe_cnt;
  logic [3:0] ce_or;
  logic       dben_low, data_moved;
  logic [7:0] oe_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    else
      passed++;
  endtask

  function automatic exp_t mk(input logic [3:0] ce, input int rd, input int wr, input logic dben_low,
                              input logic oe, input logic [7:0] data, input int mrdy,
                              input logic [7:0] wdata, input logic toerr);
    exp_t e;
    e.ce = ce; e.rd = rd; e.wr = wr; e.dben_low = dben_low; e.oe = oe;
    e.data = data; e.mrdy = mrdy; e.wdata = wdata; e.toerr = toerr;
    return e;
  endfunction

  task automatic clear_stats();
    rd_cnt = 0; wr_cnt = 0; mrdy_low = 0; oe_cnt = 0;
    ce_or = '0; dben_low = 1'b0; data_moved = 1'b0; oe_data = 8'h00;
  endtask

  task automatic compare_cycle();
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL scoreboard: cycle completed with no expected entry queued");
      return;
    end
    e = exp_q.pop_front();
    check("ce", ce_or, e.ce);
    check("rd_stb_count", rd_cnt, e.rd);
    check("wr_stb_count", wr_cnt, e.wr);
    check("dben_low", dben_low, e.dben_low);
    check("oe_seen", oe_cnt != 0, e.oe);
    if (e.oe) begin
      check("rdata", oe_data, e.data);
      check("rdata_stable", data_moved, 1'b0);
    end
    check("mrdy_low_clks", mrdy_low, e.mrdy);
    check("wdata", o_wdata, e.wdata);
    check("timeout_err", o_timeout_err, e.toerr);
  endtask

  initial begin : monitor
    clear_stats();
    forever begin
      @(negedge clk);
      if (o_ch_rd_stb) rd_cnt++;
      if (o_ch_wr_stb) wr_cnt++;
      ce_or = ce_or | o_ch_ce;
      if (!o_DBEN) dben_low = 1'b1;
      if (!o_MRDY) mrdy_low++;
      if (o_DATA_OE) begin
        if (oe_cnt > 0 && o_DATA !== oe_data) data_moved = 1'b1;
        oe_data = o_DATA;
        oe_cnt++;
      end
      if (clr_req) begin
        clear_stats();
        clr_req = 1'b0;
      end else if (end_req) begin
        compare_cycle();
        clear_stats();
        end_req = 1'b0;
      end
    end
  end

  task automatic wait_monitor();
    for (int k = 0; k < 5 && (end_req || clr_req); k++) @(negedge clk);
    if (end_req || clr_req) begin
      total++;
      $display("FAIL monitor_handshake: end_req=%b clr_req=%b, required 0", end_req, clr_req);
      end_req = 1'b0;
      clr_req = 1'b0;
    end
  endtask

  // stall > 0: raise all ready flags stall clocks after MRDY is first seen low; stall < 0: never.
  task automatic bus_cycle(input logic [15:0] addr, input logic rw, input logic [7:0] wd,
                           input logic [3:0] rdy, input int stall, input exp_t e);
    exp_q.push_back(e);
    @(negedge clk);
    i_ADDRESS_BUS = addr; i_RW = rw; i_DATA = wd; i_ch_ready = rdy;
    i_Q = 1'b1;
    fork
      begin
        int k1;
        repeat (4) @(negedge clk);
        i_E = 1'b1;
        repeat (4) @(negedge clk);
        i_Q = 1'b0;
        k1 = 0;
        while (o_MRDY !== 1'b1 && k1 < 200) begin @(negedge clk); k1++; end
        if (k1 >= 200) begin
          total++;
          $display("FAIL mrdy_release: o_MRDY=%b after %0d clk, required 1", o_MRDY, k1);
        end
        repeat (3) @(negedge clk);
        i_E = 1'b0;
        repeat (6) @(negedge clk);
      end
      begin
        int k2;
        if (stall > 0) begin
          k2 = 0;
          while (o_MRDY !== 1'b0 && k2 < 50) begin @(negedge clk); k2++; end
          repeat (stall - 1) @(negedge clk);
          i_ch_ready = 4'hF;
        end
      end
    join
    i_ch_ready = 4'hF;
    end_req = 1'b1;
    wait_monitor();
  endtask

  initial begin : stimulus
    int k;
    int stb;
    reset = 1'b0;
    i_ADDRESS_BUS = 16'h0000; i_RW = 1'b1; i_E = 1'b0; i_Q = 1'b0; i_DATA = 8'h00;
    i_ch_rdata = {8'h44, 8'hC3, 8'h77, 8'h5A};
    i_ch_ready = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_data", o_DATA, 8'h00);
    check("rst_oe", o_DATA_OE, 1'b0);
    check("rst_ce", o_ch_ce, 4'b0000);
    check("rst_strobes", {o_ch_rd_stb, o_ch_wr_stb}, 2'b00);
    check("rst_wdata", o_wdata, 8'h00);
    check("rst_mrdy", o_MRDY, 1'b1);
    check("rst_dben", o_DBEN, 1'b1);
    check("rst_timeout_err", o_timeout_err, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    clr_req = 1'b1;
    wait_monitor();

    bus_cycle(16'hA000, 1'b1, 8'h00, 4'hF, 0, mk(4'b0001, 1, 0, 1'b1, 1'b1, 8'h5A, 0, 8'h00, 1'b0));
    bus_cycle(16'hA001, 1'b0, 8'h3C, 4'hF, 0, mk(4'b0010, 0, 1, 1'b1, 1'b0, 8'h00, 0, 8'h3C, 1'b0));
    bus_cycle(16'hF123, 1'b1, 8'h00, 4'b1011, 10, mk(4'b0100, 1, 0, 1'b1, 1'b1, 8'hC3, 10, 8'h3C, 1'b0));
    bus_cycle(16'h8000, 1'b1, 8'h00, 4'hF, 0, mk(4'b0000, 0, 0, 1'b0, 1'b0, 8'h00, 0, 8'h3C, 1'b0));
    bus_cycle(16'h0123, 1'b1, 8'h00, 4'hF, 0, mk(4'b1000, 1, 0, 1'b1, 1'b1, 8'h44, 0, 8'h3C, 1'b0));
    bus_cycle(16'hA000, 1'b0, 8'h96, 4'hF, 0, mk(4'b0001, 0, 1, 1'b1, 1'b0, 8'h00, 0, 8'h96, 1'b0));

    // Abort a stretched read with reset: outputs must drop asynchronously.
    @(negedge clk);
    i_ADDRESS_BUS = 16'hF123; i_RW = 1'b1; i_ch_ready = 4'b1011;
    i_Q = 1'b1;
    k = 0;
    while (o_MRDY !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    check("abort_reached_wait", o_MRDY, 1'b0);
    i_E = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_mrdy", o_MRDY, 1'b1);
    check("abort_ce", o_ch_ce, 4'b0000);
    check("abort_oe", o_DATA_OE, 1'b0);
    check("abort_dben", o_DBEN, 1'b1);
    i_Q = 1'b0; i_E = 1'b0; i_ch_ready = 4'hF;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    stb = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_ch_rd_stb || o_ch_wr_stb) stb++;
    end
    check("abort_no_strobe", stb, 0);
    clr_req = 1'b1;
    wait_monitor();

    bus_cycle(16'hA001, 1'b1, 8'h00, 4'hF, 0, mk(4'b0010, 1, 0, 1'b1, 1'b1, 8'h77, 0, 8'h00, 1'b0));

`ifdef BUS_CYCLE_CONTROLLER_TIMEOUT_EN
    bus_cycle(16'hF000, 1'b1, 8'h00, 4'b1011, -1, mk(4'b0100, 1, 0, 1'b1, 1'b1, 8'hFF, 64, 8'h00, 1'b1));
`endif

    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
